// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin arbiter subsystem.
// Client FSM states and the client count used by the arbiter.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACTIVE  = 2'd1,
        ST_RELEASE = 2'd2
    } arb_client_state_t;

endpackage

// File: rtl/arb_client_if.sv
// Command, upstream data, arbiter and bus signals of one arb_client.
// master: the client side; slave: local master plus arbiter plus bus.
interface arb_client_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int WAIT_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              up_valid;
    logic              up_ready;
    logic [DATA_W-1:0] up_data;
    logic              req;
    logic              grant;
    logic              ack;
    logic              bus_valid;
    logic [DATA_W-1:0] bus_data;
    logic              busy;
    logic [WAIT_W-1:0] wait_cycles;
    logic              starve;

    modport master (
        input  cmd_valid, cmd_len, up_valid, up_data, grant,
        output cmd_ready, up_ready, req, ack, bus_valid,
        output bus_data, busy, wait_cycles, starve
    );

    modport slave (
        output cmd_valid, cmd_len, up_valid, up_data, grant,
        input  cmd_ready, up_ready, req, ack, bus_valid,
        input  bus_data, busy, wait_cycles, starve
    );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, pointers carry a wrap bit for full/empty.
// Head entry is visible on dout while not empty.
module sync_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_an,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/arb_client.sv
// Requester agent: queues commands, requests the bus, streams beats.
// Acks the last beat, then drops req for one cycle so the arbiter rotates.
module arb_client
    import arb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LEN_W        = 4,
    parameter int CMD_DEPTH    = 4,
    parameter int WAIT_W       = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic         clk,
    input  logic         rst_an,
    arb_client_if.master bus
);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [WAIT_W-1:0] STARVE_AT = WAIT_W'(STARVE_LIMIT);

    arb_client_state_t state_q;
    arb_client_state_t state_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LEN_W-1:0]  head_len;

    logic [LEN_W-1:0]  beat_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cycles_q;
    logic              first_seen;
    logic              starve_q;

    logic              in_active;
    logic              fire;
    logic              last;

    assign in_active = (state_q == ST_ACTIVE);
    assign fire      = in_active && bus.grant && bus.up_valid;
    assign last      = fire && (beat_cnt == '0);
    assign fifo_push = bus.cmd_valid && !fifo_full;
    assign fifo_pop  = last;

    sync_fifo #(
        .W     (LEN_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_an(rst_an),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.cmd_len),
        .dout  (head_len),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_an) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state: load on queued command, release after last beat.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (!fifo_empty) state_d = ST_ACTIVE;
            ST_ACTIVE:  if (last)        state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; beats only move while granted in ACTIVE.
    always_comb begin
        bus.req       = in_active;
        bus.up_ready  = fire;
        bus.bus_valid = fire;
        bus.ack       = last;
    end

    assign bus.bus_data    = bus.up_data;
    assign bus.cmd_ready   = !fifo_full;
    assign bus.busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign bus.wait_cycles = wait_cycles_q;
    assign bus.starve      = starve_q;

    // Beat countdown and grant-latency counting for the current command.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            first_seen <= 1'b0;
        end else if (state_q == ST_IDLE && !fifo_empty) begin
            beat_cnt   <= head_len;
            wait_cnt   <= '0;
            first_seen <= 1'b0;
        end else if (in_active) begin
            if (fire && beat_cnt != '0)
                beat_cnt <= beat_cnt - 1'b1;
            if (!first_seen && bus.grant)
                first_seen <= 1'b1;
            if (!first_seen && !bus.grant && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Latency capture on first grant and sticky starvation flag.
    always_ff @(posedge clk) begin
        if (!rst_an) begin
            wait_cycles_q <= '0;
            starve_q      <= 1'b0;
        end else begin
            if (in_active && !first_seen && bus.grant)
                wait_cycles_q <= wait_cnt;
            if (wait_cnt == STARVE_AT)
                starve_q <= 1'b1;
        end
    end
endmodule

// File: doc/arb_client.md
# arb_client

Requester-side agent for the round-robin arbiter's req/grant/ack handshake. Queues transfer commands from a local master, raises `req`, streams the command's data beats onto the shared bus while `grant` is held, and signals completion with a one-cycle `ack` on the last beat. One instance sits in front of each arbiter request port, so the arbiter and its clients form a complete bus-sharing subsystem.

## Interface
- `DATA_W`, 32, bus/data width
- `LEN_W`, 4, command length field width; a command carries beats−1, so 1..2^LEN_W beats
- `CMD_DEPTH`, 4, command FIFO depth, power of two, ≥2
- `WAIT_W`, 8, width of the grant-latency counter
- `STARVE_LIMIT`, 200, grant-wait cycles that set `starve`; < 2^WAIT_W
---
- `clk`  in  1  clock, all logic on rising edge
- `rst_an`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command FIFO not full
- `cmd_len`  in  LEN_W  beats−1 of the offered command
- `up_valid`  in  1  upstream data beat available
- `up_ready`  out  1  beat consumed this cycle
- `up_data`  in  DATA_W  upstream data
- `req`  out  1  to arbiter: request
- `grant`  in  1  from arbiter: bus owned this cycle
- `ack`  out  1  to arbiter: last beat of command, release
- `bus_valid`  out  1  beat driven on the bus
- `bus_data`  out  DATA_W  bus data, equals `up_data`
- `busy`  out  1  state ≠ IDLE or FIFO non-empty
- `wait_cycles`  out  WAIT_W  grant latency of most recent command
- `starve`  out  1  sticky: some wait reached STARVE_LIMIT

## Operation
- FSM states: IDLE, ACTIVE, RELEASE.
- IDLE: `req`=0; FIFO non-empty → ACTIVE at next edge, loading head length into `beat_cnt`, clearing `wait_cnt` and `first_seen`.
- ACTIVE: `req`=1. Beat fires when `grant && up_valid`: `up_ready`=`bus_valid`=1, `beat_cnt` decrements. Firing beat with `beat_cnt`==0 → `ack`=1 (combinational, same cycle), FIFO pop, → RELEASE.
- RELEASE: `req`=0 for exactly one cycle (lets arbiter rotate), then IDLE.
- `grant` outside ACTIVE is ignored; `up_ready`, `bus_valid`, `ack` stay 0.
- Grant removed mid-command: beats stall, `req` stays 1, `beat_cnt` held, resume on regrant.
- `grant` high with `up_valid` low: no beat, no ack; counter unchanged.
- Wait counter: in ACTIVE while `!first_seen && !grant`, `wait_cnt` increments, saturating at 2^WAIT_W−1. First cycle with `grant` in ACTIVE: `wait_cycles` ← `wait_cnt`, `first_seen` ← 1. `wait_cnt` == STARVE_LIMIT sets `starve`; cleared only by reset.
- `cmd_ready` = !full, independent of same-cycle pop; push when full impossible.
- Push and pop same cycle (not full): both occur, occupancy unchanged.

## Timing
- Reset (`rst_an`=0 at an edge): state IDLE, FIFO empty, `beat_cnt`/`wait_cnt`/`first_seen`=0; all outputs 0 except `cmd_ready`=1. Applies mid-command: transfer abandoned, no `ack`.
- Command accepted at edge t → FIFO non-empty after t → ACTIVE, `req`=1 from edge t+1.
- Grant held continuously, `up_valid` high: N-beat command occupies N cycles; `ack` in cycle N.
- `req` falls at the edge after `ack`, low ≥1 cycle; next queued command re-raises `req` two edges after `ack` edge.
- Back-to-back commands: minimum period N+2 cycles (N beats, RELEASE, IDLE).
- `wait_cycles` updates at the edge closing the first granted cycle.

## Structure
- Package `arb_pkg`: FSM state enum (`arb_client_state_t`), shared `N_REQ` client-count constant used with the arbiter.
- Sub-module `sync_fifo` (width LEN_W, depth CMD_DEPTH, full/empty, registered pointers with wrap bit); rest in `arb_client`.

## Test plan
- Reset, push `cmd_len`=3, grant held from `req` rise, `up_valid`=1 → four `bus_valid` beats with data D0..D3, `ack` on 4th only, `req` low next cycle, `wait_cycles`=0.
- Grant delayed 5 cycles after `req` → `wait_cycles`=5; grant dropped after beat 1 for 3 cycles → `req` stays 1, beats 2–4 resume, single `ack`.
- Push 4 commands with no grant → `cmd_ready`=0 after 4th; 5th offer not taken; after each `ack` one slot frees, commands complete in order with lengths as pushed.
- Grant withheld 200 cycles → `starve`=1 and remains 1 after later commands complete; reset → 0.
- `rst_an`=0 mid-command (beat 2 of 8) → next cycle `req`=0, `busy`=0, `cmd_ready`=1, no `ack`; new command then runs normally.
- `grant` pulses in IDLE and RELEASE, `up_valid` gaps in ACTIVE → no beat or ack outside ACTIVE; ack only on a valid last beat.
